store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Decoupled write buffer between the memory-stage ALU address/data path and dataMemory.
- Accepts stores from the pipeline and queues them in a small FIFO.
- Drains queued stores into dataMemory one per idle cycle.
- Arbitrates dataMemory's single address port between load reads and buffered writes, and forwards buffered data to younger loads (read-after-write safety).

Parameters:
- DEPTH, 4, number of store entries; power of two, minimum 2.
- ADDR_WIDTH, 32, address width; matches the ALUMemAdd bus.
- DATA_WIDTH, 32, data width; matches the writeDataM bus.

Ports:
- CLK  in  1  system clock, all state on posedge
- RST  in  1  synchronous active-high reset
- storeEn  in  1  store request from memory stage
- storeAdd  in  ADDR_WIDTH  store address
- storeData  in  DATA_WIDTH  store data
- loadEn  in  1  load request from memory stage
- loadAdd  in  ADDR_WIDTH  load address
- loadData  out  DATA_WIDTH  load result (forwarded or memory)
- stallM  out  1  memory stage must hold its current instruction
- empty  out  1  no stores pending (end-of-program drain indicator)
- memWriteEn  out  1  to dataMemory writeEn
- memAdd  out  ADDR_WIDTH  to dataMemory ALUMemAdd
- memWriteData  out  DATA_WIDTH  to dataMemory writeDataM
- memReadData  in  DATA_WIDTH  from dataMemory readDataW (combinational)

Behaviour:
- State: entry arrays (addr, data, valid), head/tail pointers, and count (0..DEPTH).
- full = (count==DEPTH); empty = (count==0). Both are decoded from registered state.
- Reset: count=0, head=tail=0, all valid=0. Resulting outputs: empty=1, stallM=0, memWriteEn=0, memAdd=0 when idle, loadData=memReadData.
- Reset mid-operation discards all pending stores; no write is issued in the reset cycle.
- Port arbitration (combinational, per cycle):
  - If loadEn and not full: load owns the port. memAdd=loadAdd, memWriteEn=0, no drain.
  - Else if count>0: drain the head entry. memWriteEn=1, memAdd=addr[head], memWriteData=data[head]. Head advances and the entry is invalidated at posedge.
  - Else: memWriteEn=0, memAdd=0.
- Full with loadEn: drain wins (prevents deadlock). stallM=1 and the load is not serviced; it retries next cycle.
- Store accept:
  - Accepted when storeEn and not full. Entry written at tail at posedge; tail advances.
  - storeEn while full: stallM=1, store not accepted; upstream holds it.
  - A drain in the same cycle does not make room for a store in that cycle (full is registered).
- stallM = full and (storeEn or loadEn). storeEn and loadEn are mutually exclusive from upstream; if both are asserted, the store takes precedence and the load is ignored.
- Forwarding:
  - loadData = data of the youngest valid entry whose addr==loadAdd; otherwise memReadData.
  - The search covers registered entries only. A store enqueued in the same cycle is not visible.
  - An entry being drained in the same cycle is still visible. (The drain and load cannot coincide anyway, except in the full case, where the load is stalled.)
- Simultaneous accept and drain: count unchanged; pointers both advance.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Latency:
  - Store to memory write: minimum 1 cycle (accepted at edge N, written at edge N+1 if no load intervenes).
  - Load: 0-cycle combinational result.
- Ordering: drains are strictly FIFO. Multiple stores to the same address all drain, in program order.

Decomposition:
- Package store_buffer_pkg holds:
  - SB_DEPTH, SB_PTR_W = clog2(DEPTH), SB_ADDR_W, SB_DATA_W
  - an entry struct (valid, addr, data)
- One sub-module, sb_match_unit: combinational youngest-match search over the entries. Takes the entries, head, count and loadAdd; returns hit and hitData. Priority is from tail-1 backward to head.

Test Plan:
- Reset then idle: RST high 2 cycles -> empty=1, stallM=0, memWriteEn=0. Assert RST with 3 pending stores -> next cycle empty=1 and none written.
- Single store: store 0x10<-0xDEADBEEF, no loads -> next cycle memWriteEn=1, memAdd=0x10, memWriteData=0xDEADBEEF; following cycle empty=1.
- Forwarding: store 0x20<-0x1, then 0x20<-0x2, then load 0x20 on consecutive cycles (writes held off by loads) -> loadData=0x2. Load 0x24 -> loadData=memReadData.
- Full/stall: 4 stores back-to-back with loadEn held high -> full. Fifth store -> stallM=1, drain of first entry issues despite loadEn. Fifth store is accepted the cycle after full deasserts.
- Ordering/wrap: 10 stores to addresses 0..9 with loads interleaved every other cycle -> memory writes appear in order 0..9, pointers wrap twice, final empty=1.
- Same-cycle store+load to same address: store 0x30<-0x5 and load 0x30 asserted together (precedence check) -> store accepted, load ignored. Next-cycle load 0x30 returns 0x5 from the buffer.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared sizing and entry layout for the memory-stage store buffer.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH  = 4;
  localparam int unsigned SB_PTR_W  = $clog2(SB_DEPTH);
  localparam int unsigned SB_ADDR_W = 32;
  localparam int unsigned SB_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match_unit.sv
// Youngest-match search over queued stores for load forwarding.
module sb_match_unit
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  sb_entry_t            entries [DEPTH],
  input  logic [PtrW-1:0]      head,
  input  logic [PtrW:0]        count,
  input  logic [SB_ADDR_W-1:0] loadAdd,
  output logic                 hit,
  output logic [SB_DATA_W-1:0] hitData
);

  logic [PtrW-1:0] idx;

  // Walk oldest to youngest; later hits overwrite, so the youngest match wins.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    idx     = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = head + PtrW'(i);
      if (i < int'(count) && entries[idx].valid && entries[idx].addr == loadAdd) begin
        hit     = 1'b1;
        hitData = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// FIFO write buffer between the memory stage and dataMemory, with port
// arbitration (loads first unless full) and store-to-load forwarding.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH      = SB_DEPTH,
  parameter int unsigned ADDR_WIDTH = SB_ADDR_W,
  parameter int unsigned DATA_WIDTH = SB_DATA_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  storeEn,
  input  logic [ADDR_WIDTH-1:0] storeAdd,
  input  logic [DATA_WIDTH-1:0] storeData,
  input  logic                  loadEn,
  input  logic [ADDR_WIDTH-1:0] loadAdd,
  output logic [DATA_WIDTH-1:0] loadData,
  output logic                  stallM,
  output logic                  empty,
  output logic                  memWriteEn,
  output logic [ADDR_WIDTH-1:0] memAdd,
  output logic [DATA_WIDTH-1:0] memWriteData,
  input  logic [DATA_WIDTH-1:0] memReadData
);

  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(DEPTH);

  sb_entry_t       entries_q [DEPTH];
  sb_entry_t       entries_d [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PtrW:0]   count_q, count_d;

  logic full, load_owns, drain, store_acc;
  logic hit;
  logic [DATA_WIDTH-1:0] hit_data;

  sb_match_unit #(
    .DEPTH (DEPTH)
  ) u_match (
    .entries (entries_q),
    .head    (head_q),
    .count   (count_q),
    .loadAdd (loadAdd),
    .hit     (hit),
    .hitData (hit_data)
  );

  always_comb begin
    full      = (count_q == FullCount);
    empty     = (count_q == '0);
    // A raised loadEn holds the port even when a store wins precedence.
    load_owns = loadEn && !full;
    // No write may leave the buffer in a reset cycle.
    drain     = !RST && !load_owns && !empty;
    store_acc = storeEn && !full;
    stallM    = full && (storeEn || loadEn);

    memWriteEn   = drain;
    memWriteData = drain ? entries_q[head_q].data : '0;
    if (load_owns) begin
      memAdd = loadAdd;
    end else if (drain) begin
      memAdd = entries_q[head_q].addr;
    end else begin
      memAdd = '0;
    end
    loadData = hit ? hit_data : memReadData;
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (drain) begin
      entries_d[head_q].valid = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (store_acc) begin
      entries_d[tail_q] = '{valid: 1'b1, addr: storeAdd, data: storeData};
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + (PtrW+1)'(store_acc) - (PtrW+1)'(drain);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, FIFO-order and
// randomized traffic checked against a queue-based model of the buffer.
module tb_store_buffer;
  import store_buffer_pkg::*;

  localparam int unsigned DEPTH = SB_DEPTH;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        storeEn = 1'b0, loadEn = 1'b0;
  logic [31:0] storeAdd = '0, storeData = '0, loadAdd = '0;
  logic [31:0] loadData, memAdd, memWriteData, memReadData;
  logic        stallM, empty, memWriteEn;

  always #5 CLK = ~CLK;

  store_buffer dut (
    .CLK          (CLK),
    .RST          (RST),
    .storeEn      (storeEn),
    .storeAdd     (storeAdd),
    .storeData    (storeData),
    .loadEn       (loadEn),
    .loadAdd      (loadAdd),
    .loadData     (loadData),
    .stallM       (stallM),
    .empty        (empty),
    .memWriteEn   (memWriteEn),
    .memAdd       (memAdd),
    .memWriteData (memWriteData),
    .memReadData  (memReadData)
  );

  // dataMemory stand-in: unwritten words read back as A000_00xx.
  logic [31:0] mem_q [256];
  bit          written [256];
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t wr_log [$];

  assign memReadData = written[memAdd[7:0]] ? mem_q[memAdd[7:0]]
                                            : (32'hA000_0000 | {24'h0, memAdd[7:0]});

  always @(posedge CLK) begin
    if (memWriteEn === 1'b1) begin
      mem_q[memAdd[7:0]]   <= memWriteData;
      written[memAdd[7:0]] <= 1'b1;
      wr_log.push_back('{memAdd, memWriteData});
    end
  end

  typedef struct {
    bit rst; bit se; logic [31:0] sa; logic [31:0] sd; bit le; logic [31:0] la;
    bit chk; bit es; bit ee; bit ew; logic [31:0] ea; logic [31:0] ewd;
    bit cl; logic [31:0] eld;
  } vec_t;

  function automatic vec_t mk(bit rst, bit se, logic [31:0] sa, logic [31:0] sd, bit le,
                              logic [31:0] la, bit chk, bit es, bit ee, bit ew,
                              logic [31:0] ea, logic [31:0] ewd, bit cl, logic [31:0] eld);
    vec_t v;
    v = '{rst, se, sa, sd, le, la, chk, es, ee, ew, ea, ewd, cl, eld};
    return v;
  endfunction

  // Reference model: pending stores in program order plus expected memory image.
  sb_entry_t   mq [$];
  logic [31:0] exp_mem [int];
  bit          mvalid = 1'b0;
  int          tests = 0, fails = 0;

  function automatic logic [31:0] mem_val(logic [31:0] a);
    if (exp_mem.exists(int'(a[7:0]))) return exp_mem[int'(a[7:0])];
    return 32'hA000_0000 | {24'h0, a[7:0]};
  endfunction

  function automatic logic [31:0] fwd_or_mem(logic [31:0] a);
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) return mq[i].data;
    end
    return mem_val(a);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(vec_t v);
    bit full_m, owns, drain_m;
    RST = v.rst; storeEn = v.se; storeAdd = v.sa; storeData = v.sd;
    loadEn = v.le; loadAdd = v.la;
    @(negedge CLK);
    full_m  = (mq.size() == DEPTH);
    owns    = v.le && !full_m;
    drain_m = !v.rst && !owns && mq.size() > 0;
    if (mvalid) begin
      chk("stallM", 32'(stallM), 32'(full_m && (v.se || v.le)));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("memWriteEn", 32'(memWriteEn), 32'(drain_m));
      chk("memAdd", memAdd, owns ? v.la : (drain_m ? mq[0].addr : 32'h0));
      if (drain_m) chk("memWriteData", memWriteData, mq[0].data);
      if (v.le && !full_m) chk("loadData", loadData, fwd_or_mem(v.la));
    end
    if (v.chk) begin
      chk("tbl_stallM", 32'(stallM), 32'(v.es));
      chk("tbl_empty", 32'(empty), 32'(v.ee));
      chk("tbl_memWriteEn", 32'(memWriteEn), 32'(v.ew));
      chk("tbl_memAdd", memAdd, v.ea);
      if (v.ew) chk("tbl_memWriteData", memWriteData, v.ewd);
      if (v.cl) chk("tbl_loadData", loadData, v.eld);
    end
    @(posedge CLK);
    if (v.rst) begin
      mq.delete();
      mvalid = 1'b1;
    end else begin
      if (drain_m) begin
        exp_mem[int'(mq[0].addr[7:0])] = mq[0].data;
        void'(mq.pop_front());
      end
      if (v.se && !full_m) mq.push_back('{1'b1, v.sa, v.sd});
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [$];
    vec_t v;
    int   base;

    //                rst se  sa     sd          le  la    chk es ee ew ea     ewd   cl eld
    tbl.push_back(mk(1, 0, 0,     0,          0, 0,     0, 0, 0, 0, 0,     0,    0, 0));
    tbl.push_back(mk(1, 0, 0,     0,          0, 0,     1, 0, 1, 0, 0,     0,    0, 0));
    tbl.push_back(mk(0, 1, 'h10,  'hDEADBEEF, 0, 0,     1, 0, 1, 0, 0,     0,    0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 0, 1, 'h10, 'hDEADBEEF, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 1, 0, 0,     0,    0, 0));
    tbl.push_back(mk(0, 1, 'h20,  1,          0, 0,     1, 0, 1, 0, 0,     0,    0, 0));
    tbl.push_back(mk(0, 1, 'h20,  2,          0, 0,     1, 0, 0, 1, 'h20,  1,    0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          1, 'h20,  1, 0, 0, 0, 'h20,  0,    1, 2));
    tbl.push_back(mk(0, 0, 0,     0,          1, 'h24,  1, 0, 0, 0, 'h24,  0,    1, 'hA0000024));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 0, 1, 'h20,  2,    0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          1, 'h20,  1, 0, 1, 0, 'h20,  0,    1, 2));
    tbl.push_back(mk(0, 1, 'h30,  5,          1, 'h30,  1, 0, 1, 0, 'h30,  0,    0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          1, 'h30,  1, 0, 0, 0, 'h30,  0,    1, 5));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 0, 1, 'h30,  5,    0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 1, 0, 0,     0,    0, 0));
    // Fill to full with loads holding the port, then overflow.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1, 'h50 + i, 'h50 + i, 1, 'hF0, 1, 0, i == 0, 0, 'hF0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h54,  'h54,       1, 'hF0,  1, 1, 0, 1, 'h50,  'h50, 0, 0));
    tbl.push_back(mk(0, 1, 'h54,  'h54,       1, 'hF0,  1, 0, 0, 0, 'hF0,  0,    0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          1, 'h52,  1, 1, 0, 1, 'h51,  'h51, 1, 'h52));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 0, 1, 'h52,  'h52, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 0, 1, 'h53,  'h53, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 0, 1, 'h54,  'h54, 0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 1, 0, 0,     0,    0, 0));
    // Three pending stores discarded by reset.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 'h60 + i, 'h77, 1, 'hF0, 1, 0, i == 0, 0, 'hF0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 'h63,  'h77,       0, 0,     1, 0, 0, 0, 0,     0,    0, 0));
    tbl.push_back(mk(0, 0, 0,     0,          0, 0,     1, 0, 1, 0, 0,     0,    0, 0));

    @(posedge CLK);
    #1;
    foreach (tbl[i]) step(tbl[i]);
    for (int i = 0; i < 4; i++) chk("rst_discard_nowrite", 32'(written[8'h60 + i]), 0);

    // FIFO order across two pointer wraps, loads interleaved.
    base = wr_log.size();
    for (int i = 0; i < 10; i++) begin
      step(mk(0, 1, i, 'h100 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      step(mk(0, 0, 0, 0, 1, 'hF0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("order_write_count", wr_log.size() - base, 10);
    for (int i = 0; i < 10; i++) begin
      if (base + i < wr_log.size()) begin
        chk("order_addr", wr_log[base + i].a, i);
        chk("order_data", wr_log[base + i].d, 'h100 + i);
      end
    end
    chk("order_empty", 32'(empty), 1);

    // Randomized traffic over a small address range to exercise forwarding.
    for (int n = 0; n < 3000; n++) begin
      v = mk(($urandom % 100) == 0, $urandom % 2, $urandom % 8, $urandom,
             ($urandom % 3) != 0, $urandom % 8, 0, 0, 0, 0, 0, 0, 0, 0);
      step(v);
    end
    for (int n = 0; n < DEPTH + 1; n++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("final_drained_empty", 32'(empty), 1);
    for (int a = 0; a < 8; a++) begin
      loadEn = 1'b1; loadAdd = a;
      #1;
      chk("final_mem_image", loadData, mem_val(a));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
